// File: rtl/dac_sched_pkg.sv
// Shared types and helpers for the DAC update scheduler.
//   state_t  : scheduler FSM states (3-bit, IDLE=0 .. WAIT_DAC=7)
//   WORD_W   : width of one DAC command word
//   MAX_CH   : upper bound on channel count handled by rr_pick
//   rr_pick  : round-robin pick of the lowest pending index at or after ptr
package dac_sched_pkg;

  localparam int unsigned WORD_W = 24;
  localparam int unsigned MAX_CH = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    POP      = 3'd2,
    START    = 3'd3,
    WAIT_HI  = 3'd4,
    WAIT_LO  = 3'd5,
    LDAC     = 3'd6,
    WAIT_DAC = 3'd7
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } pick_t;

  // Search n channels starting at ptr, wrapping at n; ptr is always < n,
  // so ptr+k never reaches 2n and a single subtract replaces the modulo.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0] pending,
                                    input logic [3:0] ptr,
                                    input int unsigned n);
    pick_t       r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      if (k < n && !r.valid) begin
        j = 32'(ptr) + k;
        if (j >= n) j = j - n;
        if (pending[j[3:0]]) begin
          r.valid = 1'b1;
          r.idx   = j[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   pending : request vector
//   ptr     : first index to consider (rotating priority)
//   idx     : granted index
//   grant   : one-hot grant (all zero when nothing pending)
//   valid   : a grant was made
module rr_arbiter
  import dac_sched_pkg::*;
#(
  parameter int unsigned N  = 1,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic [N-1:0]  grant,
  output logic          valid
);

  pick_t             p;
  logic [MAX_CH-1:0] pend_ext;

  always_comb begin
    pend_ext         = '0;
    pend_ext[N-1:0]  = pending;
    p                = rr_pick(pend_ext, 4'(ptr), N);
    valid            = p.valid;
    idx              = p.idx[PW-1:0];
    grant            = '0;
    for (int unsigned i = 0; i < N; i++)
      if (p.valid && 32'(p.idx) == i) grant[i] = 1'b1;
  end

endmodule

// File: rtl/dac_update_scheduler.sv
// Shares one SPI transmitter among DACN per-DAC FIFOs. Each pass snapshots
// the non-empty FIFOs, sends at most one word per channel in round-robin
// order, then pulses LDAC on every written DAC together and waits for the
// DACs to report not-busy.
//   clock, reset_n      : clk_50, async active-low reset
//   enable              : allow new passes
//   fifo_empty/data/read: show-ahead FIFO bank interface (one-hot pop)
//   spi_data/start/busy : shared transmitter interface
//   spi_sel             : one-hot frame routing select
//   dac_busy_n          : async DAC busy flags (synchronized here)
//   dac_ldac_n          : active-low load strobes
//   idle/pass_done/error: status (error is sticky)
module dac_update_scheduler
  import dac_sched_pkg::*;
#(
  parameter int unsigned DACN          = 1,
  parameter int unsigned LDAC_CYCLES   = 4,
  parameter int unsigned START_TIMEOUT = 15,
  parameter int unsigned DAC_TIMEOUT   = 1023
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [DACN-1:0]        fifo_empty,
  input  logic [WORD_W*DACN-1:0] fifo_data,
  output logic [DACN-1:0]        fifo_read,
  output logic [WORD_W-1:0]      spi_data,
  output logic                   spi_start,
  input  logic                   spi_busy,
  output logic [DACN-1:0]        spi_sel,
  input  logic [DACN-1:0]        dac_busy_n,
  output logic [DACN-1:0]        dac_ldac_n,
  output logic                   idle,
  output logic                   pass_done,
  output logic                   error
);

  localparam int unsigned PW   = (DACN > 1) ? $clog2(DACN) : 1;
  localparam int unsigned TMAX = (DAC_TIMEOUT > START_TIMEOUT) ? DAC_TIMEOUT : START_TIMEOUT;
  localparam int unsigned CMAX = (TMAX > LDAC_CYCLES) ? TMAX : LDAC_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] LDAC_LAST  = CW'(LDAC_CYCLES - 1);
  localparam logic [CW-1:0] DAC_LAST   = CW'(DAC_TIMEOUT - 1);

  state_t            state;
  logic [DACN-1:0]   pending, written, cur_oh;
  logic [PW-1:0]     rr_ptr, cur;
  logic [CW-1:0]     cnt;
  logic [DACN-1:0]   busy_s1, busy_s2;
  logic [PW-1:0]     pick_idx;
  logic [DACN-1:0]   pick_oh;
  logic              pick_valid;
  logic [WORD_W-1:0] head;
  logic              dac_ok;

  rr_arbiter #(.N(DACN), .PW(PW)) u_arb (
    .pending (pending),
    .ptr     (rr_ptr),
    .idx     (pick_idx),
    .grant   (pick_oh),
    .valid   (pick_valid)
  );

  always_comb begin
    head = '0;
    for (int unsigned i = 0; i < DACN; i++)
      if (cur_oh[i]) head = fifo_data[i*WORD_W +: WORD_W];
  end

  // Only DACs loaded in this pass gate completion.
  assign dac_ok = &(busy_s2 | ~written);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_s1 <= '1;
      busy_s2 <= '1;
    end else begin
      busy_s1 <= dac_busy_n;
      busy_s2 <= busy_s1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pending    <= '0;
      written    <= '0;
      cur_oh     <= '0;
      rr_ptr     <= '0;
      cur        <= '0;
      cnt        <= '0;
      fifo_read  <= '0;
      spi_data   <= '0;
      spi_start  <= 1'b0;
      spi_sel    <= '0;
      dac_ldac_n <= '1;
      idle       <= 1'b1;
      pass_done  <= 1'b0;
      error      <= 1'b0;
    end else begin
      fifo_read <= '0;
      spi_start <= 1'b0;
      pass_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (~fifo_empty != '0)) begin
            pending <= ~fifo_empty;
            written <= '0;
            idle    <= 1'b0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (pick_valid) begin
            cur     <= pick_idx;
            cur_oh  <= pick_oh;
            spi_sel <= pick_oh;
            state   <= POP;
          end else begin
            spi_sel <= '0;
            if (written != '0) begin
              dac_ldac_n <= ~written;
              cnt        <= '0;
              state      <= LDAC;
            end else begin
              idle  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        POP: begin
          spi_data  <= head;
          fifo_read <= cur_oh;
          pending   <= pending & ~cur_oh;
          written   <= written | cur_oh;
          rr_ptr    <= (cur == PW'(DACN - 1)) ? '0 : cur + PW'(1);
          state     <= START;
        end
        START: begin
          spi_start <= 1'b1;
          cnt       <= '0;
          state     <= WAIT_HI;
        end
        WAIT_HI: begin
          if (spi_busy) begin
            state <= WAIT_LO;
          end else if (cnt == START_LAST) begin
            error   <= 1'b1;
            spi_sel <= '0;
            state   <= SCAN;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_LO: begin
          if (!spi_busy) begin
            spi_sel <= '0;
            state   <= SCAN;
          end
        end
        LDAC: begin
          if (cnt == LDAC_LAST) begin
            dac_ldac_n <= '1;
            cnt        <= '0;
            state      <= WAIT_DAC;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_DAC: begin
          if (dac_ok || cnt == DAC_LAST) begin
            if (!dac_ok) error <= 1'b1;
            pass_done <= 1'b1;
            idle      <= 1'b1;
            state     <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
